cmplx_frac_mult: RTL and testbench

Parametrised, pipelined complex twiddle multiplier for the FFT butterfly datapath. It multiplies a signed fractional complex sample by a signed fractional complex twiddle factor, applying optional twiddle conjugation for IFFT and selectable rounding. The result is saturated back to sample width. It sits between the twiddle ROM and the butterfly add/sub stage, and uses valid/ready flow control so the butterfly scheduler can stall it.

---
 rtl/cmplx_frac_mult_pkg.sv | 19 +
 rtl/cmplx_frac_mult_if.sv | 31 +++
 rtl/cmplx_frac_mult_round_sat.sv | 34 +++
 rtl/cmplx_frac_mult.sv | 101 ++++++++++
 tb/tb_cmplx_frac_mult.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmplx_frac_mult_pkg.sv
// Shared constants and helpers for the FFT twiddle multiplier datapath.
// Holds the default Q-format widths, the rounding-mode codes and the saturation limits.
package fft_pkg;

    localparam int DW_DEF = 17;
    localparam int TW_DEF = 8;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/cmplx_frac_mult_if.sv
// Valid/ready streaming bundle between the twiddle ROM, the multiplier and the butterfly.
// The master side drives samples and consumes results; the slave side is the multiplier.
interface cmplx_frac_mult_if #(
    parameter int DW = fft_pkg::DW_DEF,
    parameter int TW = fft_pkg::TW_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic signed [TW-1:0] tw_re;
    logic signed [TW-1:0] tw_im;
    logic                 conj;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic [1:0]           out_sat;
    logic                 ovf_sticky;
    logic                 clr_ovf;

    modport master (
        output in_valid, in_re, in_im, tw_re, tw_im, conj, out_ready, clr_ovf,
        input  in_ready, out_valid, out_re, out_im, out_sat, ovf_sticky
    );

    modport slave (
        input  in_valid, in_re, in_im, tw_re, tw_im, conj, out_ready, clr_ovf,
        output in_ready, out_valid, out_re, out_im, out_sat, ovf_sticky
    );
endinterface

// File: rtl/cmplx_frac_mult_round_sat.sv
// Scales a full-precision product sum back to sample width: optional half-up rounding,
// arithmetic right shift, then clamp to the signed DW range with a saturation flag.
module frac_round_sat
    import fft_pkg::*;
#(
    parameter int IW    = 27,
    parameter int SHIFT = 7,
    parameter int ROUND = ROUND_HALF_UP,
    parameter int DW    = DW_DEF
) (
    input  logic signed [IW-1:0] din,
    output logic signed [DW-1:0] dout,
    output logic                 sat
);
    localparam logic signed [IW-1:0] MAXV = IW'(sat_max(DW));
    localparam logic signed [IW-1:0] MINV = IW'(sat_min(DW));
    localparam logic signed [IW-1:0] RND  = IW'(longint'(1) <<< (SHIFT - 1));

    function automatic logic signed [IW-1:0] round_shift(input logic signed [IW-1:0] x);
        if (ROUND != ROUND_TRUNC) return (x + RND) >>> SHIFT;
        return x >>> SHIFT;
    endfunction

    // Comparison runs at full width so every upper bit takes part in overflow detection.
    function automatic logic [DW:0] saturate(input logic signed [IW-1:0] x);
        if (x > MAXV) return {1'b1, MAXV[DW-1:0]};
        if (x < MINV) return {1'b1, MINV[DW-1:0]};
        return {1'b0, x[DW-1:0]};
    endfunction

    always_comb begin
        {sat, dout} = saturate(round_shift(din));
    end
endmodule

// File: rtl/cmplx_frac_mult.sv
// Three-stage complex twiddle multiplier with conjugation, rounding and saturation.
// Each stage holds a valid bit and loads whenever it is empty or draining forward.
module cmplx_frac_mult
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int TW    = TW_DEF,
    parameter int ROUND = ROUND_HALF_UP
) (
    input  logic              clk,
    input  logic              rst,
    cmplx_frac_mult_if.slave  bus
);
    localparam int PW = DW + TW + 1;
    localparam int SW = DW + TW + 2;

    logic vld_p0, vld_p1, vld_p2;
    logic en_p0, en_p1, en_p2;

    assign en_p2        = ~vld_p2 | bus.out_ready;
    assign en_p1        = ~vld_p1 | en_p2;
    assign en_p0        = ~vld_p0 | en_p1;
    assign bus.in_ready = en_p0;
    assign bus.out_valid = vld_p2;

    // Widening before negation keeps conj(-1.0) representable as +1.0.
    logic signed [TW:0] twi_ext, twi_adj;
    assign twi_ext = {bus.tw_im[TW-1], bus.tw_im};
    assign twi_adj = bus.conj ? -twi_ext : twi_ext;

    // S1: input register
    logic signed [DW-1:0] re_p0, im_p0;
    logic signed [TW-1:0] twr_p0;
    logic signed [TW:0]   twi_p0;

    always_ff @(posedge clk) begin
        if (en_p0 && bus.in_valid) begin
            re_p0  <= bus.in_re;
            im_p0  <= bus.in_im;
            twr_p0 <= bus.tw_re;
            twi_p0 <= twi_adj;
        end
    end

    // S2: four partial products
    logic signed [PW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;

    always_ff @(posedge clk) begin
        if (en_p1 && vld_p0) begin
            rr_p1 <= PW'(re_p0) * PW'(twr_p0);
            ii_p1 <= PW'(im_p0) * PW'(twi_p0);
            ri_p1 <= PW'(re_p0) * PW'(twi_p0);
            ir_p1 <= PW'(im_p0) * PW'(twr_p0);
        end
    end

    // S3: add/sub, scale, saturate, output register
    logic signed [SW-1:0] sum_re, sum_im;
    logic signed [DW-1:0] rs_re, rs_im;
    logic                 sat_re, sat_im;

    assign sum_re = SW'(rr_p1) - SW'(ii_p1);
    assign sum_im = SW'(ri_p1) + SW'(ir_p1);

    frac_round_sat #(.IW(SW), .SHIFT(TW - 1), .ROUND(ROUND), .DW(DW)) u_rs_re (
        .din  (sum_re),
        .dout (rs_re),
        .sat  (sat_re)
    );

    frac_round_sat #(.IW(SW), .SHIFT(TW - 1), .ROUND(ROUND), .DW(DW)) u_rs_im (
        .din  (sum_im),
        .dout (rs_im),
        .sat  (sat_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0         <= 1'b0;
            vld_p1         <= 1'b0;
            vld_p2         <= 1'b0;
            bus.out_re     <= '0;
            bus.out_im     <= '0;
            bus.out_sat    <= '0;
            bus.ovf_sticky <= 1'b0;
        end else begin
            if (en_p0) vld_p0 <= bus.in_valid;
            if (en_p1) vld_p1 <= vld_p0;
            if (en_p2) vld_p2 <= vld_p1;
            if (en_p2 && vld_p1) begin
                bus.out_re  <= rs_re;
                bus.out_im  <= rs_im;
                bus.out_sat <= {sat_im, sat_re};
            end
            if (bus.clr_ovf)
                bus.ovf_sticky <= 1'b0;
            else if (vld_p2 && bus.out_ready && (|bus.out_sat))
                bus.ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cmplx_frac_mult.sv
// Scoreboard bench: a round-half-up and a truncating instance share one stimulus stream.
module tb_cmplx_frac_mult;
    import fft_pkg::*;

    localparam int DW = 17;
    localparam int TW = 8;

    typedef struct {
        logic [DW-1:0] re, im, re_t, im_t;
        logic [1:0]    sat, sat_t;
        int            cyc;
        bit            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmplx_frac_mult_if #(.DW(DW), .TW(TW)) bus_r ();
    cmplx_frac_mult_if #(.DW(DW), .TW(TW)) bus_t ();

    cmplx_frac_mult #(.DW(DW), .TW(TW), .ROUND(ROUND_HALF_UP)) dut_r (
        .clk (clk), .rst (rst), .bus (bus_r.slave)
    );
    cmplx_frac_mult #(.DW(DW), .TW(TW), .ROUND(ROUND_TRUNC)) dut_t (
        .clk (clk), .rst (rst), .bus (bus_t.slave)
    );

    assign bus_t.in_valid  = bus_r.in_valid;
    assign bus_t.in_re     = bus_r.in_re;
    assign bus_t.in_im     = bus_r.in_im;
    assign bus_t.tw_re     = bus_r.tw_re;
    assign bus_t.tw_im     = bus_r.tw_im;
    assign bus_t.conj      = bus_r.conj;
    assign bus_t.out_ready = bus_r.out_ready;
    assign bus_t.clr_ovf   = bus_r.clr_ovf;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void scale_sat(input longint v, input bit rnd,
                                      output logic [DW-1:0] o, output logic s);
        longint t, hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -hi - 1;
        t  = rnd ? v + (longint'(1) <<< (TW - 2)) : v;
        t  = t >>> (TW - 1);
        s  = 1'b0;
        if (t > hi) begin t = hi; s = 1'b1; end
        else if (t < lo) begin t = lo; s = 1'b1; end
        o = t[DW-1:0];
    endfunction

    function automatic exp_t model(input logic signed [DW-1:0] a, b,
                                   input logic signed [TW-1:0] tr, ti, input bit cj);
        exp_t e;
        longint la, lb, lr, li, sre, sim;
        logic [DW-1:0] v;
        logic s;
        la = a; lb = b; lr = tr; li = ti;
        if (cj) li = -li;
        sre = la * lr - lb * li;
        sim = la * li + lb * lr;
        scale_sat(sre, 1'b1, v, s); e.re   = v; e.sat[0]   = s;
        scale_sat(sim, 1'b1, v, s); e.im   = v; e.sat[1]   = s;
        scale_sat(sre, 1'b0, v, s); e.re_t = v; e.sat_t[0] = s;
        scale_sat(sim, 1'b0, v, s); e.im_t = v; e.sat_t[1] = s;
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [DW-1:0] re, im, input logic [1:0] sat,
                                input logic [DW-1:0] re_t, im_t, input logic [1:0] sat_t);
        exp_t e;
        e.re = re; e.im = im; e.sat = sat;
        e.re_t = re_t; e.im_t = im_t; e.sat_t = sat_t;
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [DW-1:0] a, b, input logic [TW-1:0] tr, ti,
                        input bit cj, input exp_t e, input bit lat);
        bit acc = 1'b0;
        int n   = 0;
        bus_r.in_valid = 1'b1;
        bus_r.in_re = a; bus_r.in_im = b;
        bus_r.tw_re = tr; bus_r.tw_im = ti;
        bus_r.conj = cj;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus_r.in_ready;
            if (acc) begin
                e.cyc = cyc;
                e.lat = lat;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus_r.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_rand();
        logic signed [DW-1:0] a, b;
        logic signed [TW-1:0] tr, ti;
        bit cj;
        a  = DW'($urandom);
        b  = DW'($urandom);
        tr = TW'($urandom);
        ti = TW'($urandom);
        cj = 1'($urandom_range(0, 1));
        send(a, b, tr, ti, cj, model(a, b, tr, ti, cj), 1'b0);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", q.size(), 32'd0);
    endtask

    exp_t          e_m;
    bit            held_v = 1'b0;
    logic [DW-1:0] h_re, h_im;
    logic [1:0]    h_sat;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_r.out_valid && bus_r.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e_m = q.pop_front();
                    chk("out_re",      $unsigned(bus_r.out_re), e_m.re);
                    chk("out_im",      $unsigned(bus_r.out_im), e_m.im);
                    chk("out_sat",     bus_r.out_sat,           e_m.sat);
                    chk("trunc_valid", bus_t.out_valid,         32'd1);
                    chk("trunc_re",    $unsigned(bus_t.out_re), e_m.re_t);
                    chk("trunc_im",    $unsigned(bus_t.out_im), e_m.im_t);
                    chk("trunc_sat",   bus_t.out_sat,           e_m.sat_t);
                    if (e_m.lat) chk("latency", cyc - e_m.cyc, 32'd3);
                end
                held_v = 1'b0;
            end else if (bus_r.out_valid) begin
                if (held_v) begin
                    chk("stall_re",  $unsigned(bus_r.out_re), h_re);
                    chk("stall_im",  $unsigned(bus_r.out_im), h_im);
                    chk("stall_sat", bus_r.out_sat,           h_sat);
                end
                h_re   = bus_r.out_re;
                h_im   = bus_r.out_im;
                h_sat  = bus_r.out_sat;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stop = 1'b0;
        rst = 1'b1;
        bus_r.in_valid = 1'b0; bus_r.in_re = '0; bus_r.in_im = '0;
        bus_r.tw_re = '0; bus_r.tw_im = '0; bus_r.conj = 1'b0;
        bus_r.out_ready = 1'b0; bus_r.clr_ovf = 1'b0;
        #1;
        chk("rst_out_valid", bus_r.out_valid,           32'd0);
        chk("rst_out_re",    $unsigned(bus_r.out_re),   32'd0);
        chk("rst_out_sat",   bus_r.out_sat,             32'd0);
        chk("rst_ovf",       bus_r.ovf_sticky,          32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus_r.in_ready, 32'd1);

        // Directed cases with hand-derived results
        bus_r.out_ready = 1'b1;
        send(17'h08000, 17'h0, 8'h40, 8'h00, 1'b0,
             mk(17'h04000, 17'h0, 2'b00, 17'h04000, 17'h0, 2'b00), 1'b1);
        send(17'h0, 17'h08000, 8'h00, 8'h40, 1'b0,
             mk(17'h1C000, 17'h0, 2'b00, 17'h1C000, 17'h0, 2'b00), 1'b0);
        send(17'h0, 17'h08000, 8'h00, 8'h40, 1'b1,
             mk(17'h04000, 17'h0, 2'b00, 17'h04000, 17'h0, 2'b00), 1'b0);
        send(17'h0, 17'h08000, 8'h00, 8'h80, 1'b1,
             mk(17'h18000, 17'h0, 2'b00, 17'h18000, 17'h0, 2'b00), 1'b0);
        send(17'h00001, 17'h0, 8'h40, 8'h00, 1'b0,
             mk(17'h00001, 17'h0, 2'b00, 17'h00000, 17'h0, 2'b00), 1'b0);
        send(17'h1FFFF, 17'h0, 8'h40, 8'h00, 1'b0,
             mk(17'h00000, 17'h0, 2'b00, 17'h1FFFF, 17'h0, 2'b00), 1'b0);
        drain(50);
        chk("ovf_before_sat", bus_r.ovf_sticky, 32'd0);

        send(17'h10000, 17'h0, 8'h80, 8'h00, 1'b0,
             mk(17'h0FFFF, 17'h0, 2'b01, 17'h0FFFF, 17'h0, 2'b01), 1'b0);
        send(17'h10000, 17'h0, 8'h00, 8'h80, 1'b0,
             mk(17'h0, 17'h0FFFF, 2'b10, 17'h0, 17'h0FFFF, 2'b10), 1'b0);
        send(17'h10000, 17'h0FFFF, 8'h7F, 8'h7F, 1'b0,
             mk(17'h10000, 17'h1FFFF, 2'b01, 17'h10000, 17'h1FFFF, 2'b01), 1'b0);
        drain(50);
        @(posedge clk); #1;
        chk("ovf_set",       bus_r.ovf_sticky, 32'd1);
        chk("ovf_set_trunc", bus_t.ovf_sticky, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_held", bus_r.ovf_sticky, 32'd1);
        bus_r.clr_ovf = 1'b1;
        @(posedge clk); #1;
        bus_r.clr_ovf = 1'b0;
        chk("ovf_cleared", bus_r.ovf_sticky, 32'd0);

        // Backpressure: three accepts fill the pipe, the rest wait for out_ready
        bus_r.out_ready = 1'b0;
        repeat (3) send_rand();
        @(negedge clk);
        chk("bp_in_ready_low", bus_r.in_ready, 32'd0);
        @(posedge clk); #1;
        fork
            begin
                repeat (5) send_rand();
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus_r.out_ready = 1'b1;
            end
        join
        drain(50);

        // Random traffic with random downstream stalls
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_rand();
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    bus_r.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus_r.out_ready = 1'b1;
        drain(300);

        // Reset with three results in flight
        bus_r.out_ready = 1'b0;
        repeat (3) send_rand();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus_r.out_valid,         32'd0);
        chk("midrst_out_re",    $unsigned(bus_r.out_re), 32'd0);
        q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", bus_r.in_ready, 32'd1);
        bus_r.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_stale", bus_r.out_valid, 32'd0);
        chk("final_queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
